clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog_if.sv | 37 +++
 rtl/clk_div_prog.sv | 147 ++++++++++++++
 tb/tb_clk_div_prog.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// ---------------------------------------------------------------------------
// clk_div_prog_if
// Divisor-load handshake bundle for the programmable clock divider.
// The master offers a new divisor for one channel. The slave (the divider)
// reports through ld_ready whether that channel can take it this cycle.
//
// Signals:
//   ld_valid  master -> slave  load request
//   ld_ch     master -> slave  target channel index (CH_W bits)
//   ld_div    master -> slave  new divisor value (CNT_W bits)
//   ld_ready  slave -> master  load may be accepted this cycle
// ---------------------------------------------------------------------------
interface clk_div_prog_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 32
);
    logic             ld_valid;
    logic [CH_W-1:0]  ld_ch;
    logic [CNT_W-1:0] ld_div;
    logic             ld_ready;

    // The requester drives the load fields and watches ld_ready.
    modport master (
        output ld_valid,
        output ld_ch,
        output ld_div,
        input  ld_ready
    );

    // The divider consumes the load fields and answers with ld_ready.
    modport slave (
        input  ld_valid,
        input  ld_ch,
        input  ld_div,
        output ld_ready
    );
endinterface

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
// This module contains NUM_CH independent programmable clock dividers.
// Each channel counts enabled clk edges up to its active divisor. When the
// count reaches the divisor, the channel wraps, toggles its divided clock and
// pulses tick for one cycle. The output period is therefore 2*(div+1) clk
// cycles with a 50% duty cycle.
//
// A new divisor is first written into a per-channel shadow register. The
// shadow value becomes active only when the counter wraps, so a period is
// never cut short. While the shadow is waiting, ld_ready for that channel is
// low. When the global enable is off, a waiting divisor is applied on the next
// edge and the counter restarts from zero.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   n_rst       asynchronous active-low reset
//   en_i        global count enable
//   sync_clr_i  synchronous phase clear of all channels (only with
//               CLKDIV_SYNC_EN)
//   ldBus       divisor-load handshake (clk_div_prog_if.slave)
//   new_clk_o   divided clock per channel, registered
//   tick_o      one-cycle strobe per channel at each toggle, registered
//
// Optional feature macro: CLKDIV_SYNC_EN adds the sync_clr_i input.
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 24_999_999
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en_i,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_clr_i,
`endif
    clk_div_prog_if.slave     ldBus,
    output logic [NUM_CH-1:0] new_clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  div_q  [NUM_CH];
    logic [CNT_W-1:0]  div_d  [NUM_CH];
    logic [CNT_W-1:0]  sdiv_q [NUM_CH];
    logic [CNT_W-1:0]  sdiv_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] newClk_q;
    logic [NUM_CH-1:0] newClk_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic              ldReady;

    // ld_ready is low only while the addressed channel still has an unapplied
    // shadow divisor. A channel index outside the implemented range matches no
    // channel, so it stays ready, and a load to that index is dropped.
    always_comb begin
        ldReady = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ldBus.ld_ch == CH_W'(i)) begin
                ldReady = ~pend_q[i];
            end
        end
    end

    assign ldBus.ld_ready = ldReady;

    // Next-state logic for every channel.
    // A shadow divisor is applied only when pend_q is set. A load is accepted
    // only when pend_q is clear. These two events can therefore never happen
    // on the same edge. As a result, a load accepted on a wrap edge waits for
    // the following wrap. tick defaults to zero, so it lasts exactly one
    // cycle.
    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        sdiv_d   = sdiv_q;
        pend_d   = pend_q;
        newClk_d = newClk_q;
        tick_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef CLKDIV_SYNC_EN
            if (sync_clr_i) begin
                cnt_d[i]    = '0;
                newClk_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_d[i]  = sdiv_q[i];
                    pend_d[i] = 1'b0;
                end
            end else
`endif
            if (en_i) begin
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]    = '0;
                    newClk_d[i] = ~newClk_q[i];
                    tick_d[i]   = 1'b1;
                    if (pend_q[i]) begin
                        div_d[i]  = sdiv_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (pend_q[i]) begin
                cnt_d[i]  = '0;
                div_d[i]  = sdiv_q[i];
                pend_d[i] = 1'b0;
            end

            if (ldBus.ld_valid && ldReady && (ldBus.ld_ch == CH_W'(i))) begin
                sdiv_d[i] = ldBus.ld_div;
                pend_d[i] = 1'b1;
            end
        end
    end

    // State registers. Reset puts every channel back to the default divisor.
    // Reset also drops any divisor that was still waiting in a shadow register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= DEFAULT_DIV;
                sdiv_q[i] <= DEFAULT_DIV;
            end
            pend_q   <= '0;
            newClk_q <= '0;
            tick_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            sdiv_q   <= sdiv_d;
            pend_q   <= pend_d;
            newClk_q <= newClk_d;
            tick_q   <= tick_d;
        end
    end

    assign new_clk_o = newClk_q;
    assign tick_o    = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
// This is the self-checking bench for clk_div_prog. It uses three channels,
// an 8-bit counter and a reset divisor of 1. With three channels, channel
// index 3 exists on the bus but has no matching channel, so it can be used to
// exercise the out-of-range load path.
// Every expected value is pushed into a scoreboard queue before the stimulus
// is driven. The value is then popped and compared once the DUT output has
// settled after the edge.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;
    localparam int BUDGET = 64;

    logic              clk = 1'b0;
    logic              nRst = 1'b1;
    logic              en = 1'b0;
    logic [NUM_CH-1:0] newClk;
    logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
    logic              syncClr = 1'b0;
`endif

    clk_div_prog_if #(.CH_W(CH_W), .CNT_W(CNT_W)) ldBus ();

    clk_div_prog #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (8'd1)
    ) dut (
        .clk        (clk),
        .n_rst      (nRst),
        .en_i       (en),
`ifdef CLKDIV_SYNC_EN
        .sync_clr_i (syncClr),
`endif
        .ldBus      (ldBus),
        .new_clk_o  (newClk),
        .tick_o     (tick)
    );

    // Free-running 100 MHz system clock.
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    expVal;
    } expect_t;

    typedef struct {
        logic              en;
        logic [NUM_CH-1:0] expNewClk;
        logic [NUM_CH-1:0] expTick;
    } vector_t;

    expect_t sbQueue[$];
    vector_t vectors[10];
    int      checks = 0;
    int      errors = 0;

    task automatic pushExpect(input string name, input int expVal);
        expect_t e;
        e.name   = name;
        e.expVal = expVal;
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input int actual);
        expect_t e;
        checks++;
        if (sbQueue.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard empty: got %0d, nothing expected", actual);
        end else begin
            e = sbQueue.pop_front();
            if (actual != e.expVal) begin
                errors++;
                $display("[TB] FAIL %s: got %0d, expected %0d", e.name, actual, e.expVal);
            end
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic enV, input logic valid,
                                 input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] div);
        en             = enV;
        ldBus.ld_valid = valid;
        ldBus.ld_ch    = ch;
        ldBus.ld_div   = div;
    endtask

    // Counts edges until the chosen channel toggles. The count is capped by
    // BUDGET so that a stuck output shows up as a wrong count, not a hang.
    task automatic waitToggle(input int ch, output int n);
        logic prev;
        prev = newClk[ch];
        n    = 0;
        do begin
            stepCycle();
            n++;
        end while (newClk[ch] == prev && n < BUDGET);
    endtask

    task automatic measureHalf(input string name, input int ch, input int expEdges);
        int n;
        pushExpect(name, expEdges);
        pushExpect({name, " tick"}, 1);
        waitToggle(ch, n);
        checkOutput(n);
        checkOutput(int'(tick[ch]));
    endtask

    task automatic loadChannel(input int ch, input int div);
        applyStimulus(en, 1'b1, CH_W'(ch), CNT_W'(div));
        stepCycle();
        ldBus.ld_valid = 1'b0;
    endtask

    // Hard stop in case something above ever blocks unexpectedly.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int   n;
        logic prevBit;
        logic [NUM_CH-1:0] heldNc;

        applyStimulus(1'b0, 1'b0, '0, '0);

        // The reset table uses a divisor of 1 on every channel. The enable
        // is off for two cycles in the middle, which holds the phase.
        vectors[0] = '{1'b1, 3'b000, 3'b000};
        vectors[1] = '{1'b1, 3'b111, 3'b111};
        vectors[2] = '{1'b0, 3'b111, 3'b000};
        vectors[3] = '{1'b0, 3'b111, 3'b000};
        vectors[4] = '{1'b1, 3'b111, 3'b000};
        vectors[5] = '{1'b1, 3'b000, 3'b111};
        vectors[6] = '{1'b1, 3'b000, 3'b000};
        vectors[7] = '{1'b1, 3'b111, 3'b111};
        vectors[8] = '{1'b1, 3'b111, 3'b000};
        vectors[9] = '{1'b1, 3'b000, 3'b111};

        // Asynchronous reset takes effect with no clock edge.
        #2 nRst = 1'b0;
        #1;
        pushExpect("reset newClk", 0);
        pushExpect("reset tick", 0);
        pushExpect("reset ldReady", 1);
        checkOutput(int'(newClk));
        checkOutput(int'(tick));
        checkOutput(int'(ldBus.ld_ready));
        stepCycle();
        stepCycle();
        nRst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].en, 1'b0, '0, '0);
            pushExpect($sformatf("vec%0d newClk", i), int'(vectors[i].expNewClk));
            pushExpect($sformatf("vec%0d tick", i), int'(vectors[i].expTick));
            stepCycle();
            checkOutput(int'(newClk));
            checkOutput(int'(tick));
        end

        // Channel 2 switches to divisor 5. The first wrap after the load
        // applies it.
        loadChannel(2, 5);
        measureHalf("ch2 wrap applying div5", 2, 1);
        measureHalf("ch2 half period div5", 2, 6);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 1'b1, 2'd2, 8'd0);
        #1;
        pushExpect("ch2 ready before load", 1);
        checkOutput(int'(ldBus.ld_ready));
        stepCycle();
        ldBus.ld_valid = 1'b0;
        #1;
        pushExpect("ch2 ready while pending", 0);
        checkOutput(int'(ldBus.ld_ready));
        measureHalf("ch2 old half period remainder", 2, 3);
        pushExpect("ch2 ready after wrap", 1);
        checkOutput(int'(ldBus.ld_ready));
        measureHalf("ch2 half period div0 a", 2, 1);
        measureHalf("ch2 half period div0 b", 2, 1);
        waitToggle(0, n);
        measureHalf("ch0 unperturbed", 0, 2);

        // Freezing the enable for 7 cycles mid-count stretches the half
        // period by exactly 7 cycles. Nothing moves while frozen.
        loadChannel(1, 5);
        waitToggle(1, n);
        stepCycle();
        stepCycle();
        heldNc = newClk;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b0, 2'd1, 8'd0);
            pushExpect($sformatf("en0 hold cycle %0d", k), int'({heldNc, 3'b000}));
            stepCycle();
            checkOutput(int'({newClk, tick}));
        end
        applyStimulus(1'b1, 1'b0, 2'd1, 8'd0);
        measureHalf("ch1 resume remainder", 1, 4);

        // A load to the nonexistent channel 3 is accepted and dropped.
        applyStimulus(1'b1, 1'b1, 2'd3, 8'd0);
        #1;
        pushExpect("ch3 ready", 1);
        checkOutput(int'(ldBus.ld_ready));
        stepCycle();
        ldBus.ld_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ldBus.ld_ch = CH_W'(c);
            #1;
            pushExpect($sformatf("ch%0d ready after dropped load", c), 1);
            checkOutput(int'(ldBus.ld_ready));
        end
        waitToggle(2, n);
        measureHalf("ch2 div kept 0", 2, 1);
        waitToggle(1, n);
        measureHalf("ch1 div kept 5", 1, 6);
        waitToggle(0, n);
        measureHalf("ch0 div kept 1", 0, 2);

        // A load accepted on the wrap edge itself waits for the next wrap.
        loadChannel(0, 3);
        waitToggle(0, n);
        stepCycle();
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 1'b1, 2'd0, 8'd1);
        prevBit = newClk[0];
        stepCycle();
        ldBus.ld_valid = 1'b0;
        pushExpect("ch0 wrap on load edge", 1);
        checkOutput(int'(newClk[0] != prevBit));
        measureHalf("ch0 half after same-edge load", 0, 4);
        measureHalf("ch0 half div1 a", 0, 2);
        measureHalf("ch0 half div1 b", 0, 2);

        // With the enable off, a pending divisor lands on the next edge. The
        // counter restarts and the divided clock keeps its level.
        applyStimulus(1'b0, 1'b1, 2'd2, 8'd2);
        prevBit = newClk[2];
        stepCycle();
        ldBus.ld_valid = 1'b0;
        pushExpect("ch2 ready idle pending", 0);
        checkOutput(int'(ldBus.ld_ready));
        stepCycle();
        pushExpect("ch2 ready idle applied", 1);
        pushExpect("ch2 level held idle", int'(prevBit));
        checkOutput(int'(ldBus.ld_ready));
        checkOutput(int'(newClk[2]));
        applyStimulus(1'b1, 1'b0, 2'd2, 8'd0);
        measureHalf("ch2 after idle apply", 2, 3);

        // A reset mid-period drops a pending divisor on channel 1.
        loadChannel(1, 7);
        #3 nRst = 1'b0;
        #1;
        pushExpect("midrun reset newClk", 0);
        pushExpect("midrun reset tick", 0);
        checkOutput(int'(newClk));
        checkOutput(int'(tick));
        stepCycle();
        nRst = 1'b1;
        measureHalf("ch1 first toggle after reset", 1, 2);
        measureHalf("ch1 pending discarded", 1, 2);

`ifdef CLKDIV_SYNC_EN
        // Out-of-phase channels realign on a sync_clr pulse.
        loadChannel(0, 2);
        loadChannel(1, 4);
        loadChannel(2, 6);
        repeat (9) stepCycle();
        syncClr = 1'b1;
        stepCycle();
        syncClr = 1'b0;
        pushExpect("sync_clr newClk/tick", 0);
        checkOutput(int'({newClk, tick}));
        measureHalf("ch0 half after sync_clr", 0, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
